rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter with bounded grant hold.
- Issues a one-hot grant and its 3-bit encoded index. The encoded index matches the convention of the 8-to-3 encoder: bit n -> n.
- Used to share a single downstream resource, such as the encoder datapath or a shared bus, among 8 clients.
- Fully synchronous, single clock domain.

Parameters:
MAX_HOLD, 4, max consecutive grant cycles for one owner while others wait. Legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous active-high reset
req  input  8  request vector; req[n] high = client n wants the resource
gnt  output  8  one-hot grant vector, registered; all zero when no owner
gnt_id  output  3  encoded index of the current owner, registered; 0 when gnt_valid=0
gnt_valid  output  1  high while any grant is asserted, registered

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: gnt=8'h00, gnt_id=3'd0, gnt_valid=0, state=IDLE, ptr=3'd7, hold_cnt=0.
  - ptr=7 makes the first search start at client 0.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - When valid, gnt_id == encoded index of gnt.
- Search function: first set bit of a candidate mask, scanning ptr+1, ptr+2, … mod 8 (wrap 7->0).
- States: IDLE, GRANT.
- IDLE:
  - req==0: stay in IDLE; outputs stay zero.
  - req!=0: next edge, grant the search winner over req; go to GRANT; hold_cnt=1.
  - Latency from request to grant is 1 cycle.
- GRANT, owner = gnt_id. Evaluated each edge in this priority order:
  1. req[owner]==0 (release): ptr<=owner.
     - If any other req is high, grant the search winner (started from owner+1) on this same edge, so there is no bubble; hold_cnt=1.
     - Otherwise gnt<=0, gnt_valid<=0, go to IDLE.
  2. req[owner]==1, hold_cnt==MAX_HOLD, and (req & ~gnt)!=0 (preempt): ptr<=owner; grant the search winner over req with the owner masked out; hold_cnt=1.
  3. Otherwise: keep the grant. hold_cnt increments and saturates at MAX_HOLD. With no competitor the owner keeps the grant indefinitely.
- Fairness: with all 8 requesting continuously, the grant rotates 0,1,…,7,0. Each owner holds exactly MAX_HOLD cycles.
- A newly granted client with its req already low at the next edge is released per rule 1. The minimum grant is 1 cycle.
- Requests arriving mid-grant do not disturb the current owner until release or preempt.
- Reset mid-operation: applies on the next edge regardless of state.
  - All outputs go to 0 and ptr goes to 7.
  - The arbitration after reset starts from client 0.
- hold_cnt is 4 bits wide; MAX_HOLD>15 is illegal.
- No combinational path from req to any output.

Test Plan:
1. Reset, then req=8'b00000001 at cycle 0 -> at cycle 1 gnt=8'b00000001, gnt_id=0, gnt_valid=1. Drop req at cycle 3 -> at cycle 4 gnt=0, gnt_valid=0, FSM in IDLE.
2. After reset, req=8'b10000001 held -> grant client 0 first. Drop req[0] -> next edge gnt=8'b10000000, gnt_id=7, with no idle cycle between grants.
3. MAX_HOLD=4, req=8'hFF continuous from reset -> gnt_id sequence is 0 for 4 cycles, 1 for 4, …, 7 for 4, then 0 again. gnt stays one-hot every cycle.
4. req=8'b00100000 held for 20 cycles, no other requester -> gnt_id=5 for all 20 cycles, no preemption. Raise req[2] at cycle 10 -> gnt_id becomes 2 at the next edge, since hold_cnt is already saturated at MAX_HOLD.
5. Grant held by client 3 with req=8'b00011000. Assert reset for one cycle -> outputs zero after that edge. Release reset with req unchanged -> next edge gnt_id=3, because the search restarts at client 0 and 3 is the lowest set bit.
6. Owner 6 releases while req=8'b00000110 -> next grant is client 1 (wrap 7->0->1), not client 2.

Source files
------------

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if
//   Request/grant bundle between the 8 clients and the round-robin arbiter.
//   req       : 8-bit request vector, one bit per client
//   gnt       : one-hot grant vector, all zero when nobody owns the resource
//   gnt_id    : encoded index of the current owner (bit n -> n), 0 when idle
//   gnt_valid : high while any grant is asserted
// Modports:
//   master : arbiter side (consumes req, drives the grant signals)
//   slave  : client side (drives req, consumes the grant signals)
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    modport master (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid
    );

    modport slave (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8
//   8-requester round-robin arbiter with bounded grant hold. One owner at a
//   time; the owner keeps the resource until it drops its request, or until
//   it has held MAX_HOLD consecutive cycles while another client is waiting.
//   All outputs are registered; there is no combinational path from req.
// Ports:
//   clk   : system clock, rising-edge active
//   reset : synchronous, active-high reset
//   bus   : rr_arbiter8_if.master (req in; gnt, gnt_id, gnt_valid out)
// Parameters:
//   MAX_HOLD : max consecutive grant cycles while others wait (1..15)
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter8_if.master bus
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [3:0] hold_cnt, hold_n;
    logic [7:0] gnt_q, gnt_n;
    logic [2:0] id_q, id_n;
    logic       valid_q, valid_n;

    logic       grant_now;
    logic [7:0] search_mask;
    logic [2:0] search_start;
    logic [2:0] win;
    logic [7:0] owner_oh;
    logic [7:0] others;

    // First set bit of mask scanning start+1, start+2, ... (mod 8).
    // Iterating from the far end lets the nearest hit overwrite the rest.
    function automatic logic [2:0] rr_search(input logic [7:0] mask,
                                             input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] found;
        found = '0;
        for (int unsigned i = 8; i >= 1; i--) begin
            idx = start + 3'(i);
            if (mask[idx]) found = idx;
        end
        return found;
    endfunction

    assign owner_oh = 8'b0000_0001 << id_q;
    assign others   = bus.req & ~owner_oh;

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        hold_n       = hold_cnt;
        gnt_n        = gnt_q;
        id_n         = id_q;
        valid_n      = valid_q;
        grant_now    = 1'b0;
        search_mask  = '0;
        search_start = ptr;
        win          = '0;

        case (state)
            IDLE: begin
                if (|bus.req) begin
                    grant_now    = 1'b1;
                    search_mask  = bus.req;
                    search_start = ptr;
                end else begin
                    gnt_n   = '0;
                    id_n    = '0;
                    valid_n = 1'b0;
                    hold_n  = '0;
                end
            end

            GRANT: begin
                if (!bus.req[id_q]) begin
                    // Release: hand over on the same edge if anyone else waits.
                    ptr_n = id_q;
                    if (|others) begin
                        grant_now    = 1'b1;
                        search_mask  = others;
                        search_start = id_q;
                    end else begin
                        gnt_n   = '0;
                        id_n    = '0;
                        valid_n = 1'b0;
                        hold_n  = '0;
                        state_n = IDLE;
                    end
                end else if (hold_cnt == HOLD_MAX && |others) begin
                    // Preempt: owner masked out of the search.
                    ptr_n        = id_q;
                    grant_now    = 1'b1;
                    search_mask  = others;
                    search_start = id_q;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_n = hold_cnt + 4'd1;
                end
            end

            default: state_n = IDLE;
        endcase

        if (grant_now) begin
            win     = rr_search(search_mask, search_start);
            gnt_n   = 8'b0000_0001 << win;
            id_n    = win;
            valid_n = 1'b1;
            hold_n  = 4'd1;
            state_n = GRANT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 3'd7;
            hold_cnt <= '0;
            gnt_q    <= '0;
            id_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt_q    <= gnt_n;
            id_q     <= id_n;
            valid_q  <= valid_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8
//   Scoreboard bench for rr_arbiter8. Stimulus is applied on the falling
//   edge; the reference model predicts the registered outputs after the next
//   rising edge and queues them. A monitor pops one entry per rising edge.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic reset;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: owner (-1 = none), last owner pointer, cycles held.
    int m_owner = -1;
    int m_last  = 7;
    int m_held  = 0;

    // Nearest requester after 'from', going round the ring.
    function automatic int pick(input logic [7:0] m, input int from);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = (from + k) % 8;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [7:0] r);
        exp_t       e;
        logic [7:0] rest;
        if (rst) begin
            m_owner = -1;
            m_last  = 7;
            m_held  = 0;
        end else if (m_owner < 0) begin
            if (r != 8'h00) begin
                m_owner = pick(r, m_last);
                m_held  = 1;
            end
        end else begin
            rest = r & ~(8'h01 << m_owner);
            if (!r[m_owner]) begin
                m_last  = m_owner;
                m_owner = pick(rest, m_owner);
                m_held  = (m_owner >= 0) ? 1 : 0;
            end else if (m_held == MAX_HOLD && rest != 8'h00) begin
                m_last  = m_owner;
                m_owner = pick(rest, m_owner);
                m_held  = 1;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end
        e.gnt   = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        e.id    = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        e.valid = (m_owner >= 0);
        expq.push_back(e);
    endtask

    task automatic step(input logic rst, input logic [7:0] r);
        @(negedge clk);
        reset   = rst;
        bus.req = r;
        model_step(rst, r);
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                vectors++;
                if (bus.gnt !== e.gnt || bus.gnt_id !== e.id || bus.gnt_valid !== e.valid) begin
                    miscompares++;
                    $display("FAIL grant @%0t: got gnt=%b id=%0d valid=%b, want gnt=%b id=%0d valid=%b",
                             $time, bus.gnt, bus.gnt_id, bus.gnt_valid, e.gnt, e.id, e.valid);
                end
                vectors++;
                if (!$onehot0(bus.gnt) || bus.gnt_valid !== (|bus.gnt)) begin
                    miscompares++;
                    $display("FAIL invariant @%0t: got gnt=%b valid=%b, want one-hot/zero gnt with valid=|gnt",
                             $time, bus.gnt, bus.gnt_valid);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0] r;
        logic       rst;
        reset   = 1'b1;
        bus.req = 8'h00;

        repeat (3) step(1'b1, 8'h00);

        // Single requester, grant then release to idle
        repeat (3) step(1'b0, 8'h01);
        repeat (2) step(1'b0, 8'h00);

        // 0 first, then hand-over to 7 without a bubble
        step(1'b1, 8'h00);
        repeat (3) step(1'b0, 8'h81);
        repeat (2) step(1'b0, 8'h80);
        step(1'b0, 8'h00);

        // Full-load rotation, MAX_HOLD cycles each
        step(1'b1, 8'h00);
        repeat (70) step(1'b0, 8'hFF);

        // Lone owner keeps grant; late competitor preempts after saturation
        step(1'b1, 8'h00);
        repeat (10) step(1'b0, 8'h20);
        repeat (10) step(1'b0, 8'h24);

        // Reset mid-grant, search restarts at client 0
        step(1'b1, 8'h00);
        repeat (3) step(1'b0, 8'h18);
        step(1'b1, 8'h18);
        repeat (3) step(1'b0, 8'h18);

        // Wrap 7 -> 0 -> 1 after owner 6 releases
        step(1'b1, 8'h00);
        repeat (2) step(1'b0, 8'h40);
        repeat (3) step(1'b0, 8'h06);

        // One-cycle grant, then release straight to another client
        step(1'b1, 8'h00);
        step(1'b0, 8'h10);
        step(1'b0, 8'h00);
        step(1'b0, 8'h10);
        step(1'b0, 8'h01);
        step(1'b0, 8'h01);

        // Random: sparse bit flips give long holds and contention
        r = 8'h00;
        repeat (3000) begin
            r   = r ^ 8'($urandom & $urandom & $urandom);
            rst = ($urandom_range(0, 99) == 0);
            step(rst, r);
        end

        step(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
